// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default geometry
// constants and the clear/ready controller state encoding.
package rf_pkg;

  // Default geometry used by regfile_mp and rf_scoreboard.
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRP_DEF  = 2;

  // Controller state: CLEAR walks the array writing zeros, READY serves traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard: one bit per architectural register.
// A set request marks a register as awaiting a producer; a committed write
// clears it. When both target the same register in one cycle, the set wins
// because it belongs to the newer producer. Register 0 is never marked.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRP  = NRP_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic              clr_i,
  input  logic [AW-1:0]     clr_addr_i,
  input  logic [NRP*AW-1:0] qaddr_i,
  output logic [NRP-1:0]    busy_o
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Next pending state: apply the clear first so a same-address set overrides it.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) begin
      pending_d[clr_addr_i] = 1'b0;
    end
    if (set_i && (set_addr_i != '0)) begin
      pending_d[set_addr_i] = 1'b1;
    end
  end

  // Pending-bit storage, wiped by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Query ports report the bits as registered at the start of the cycle.
  for (genvar g = 0; g < NRP; g++) begin : g_query
    assign busy_o[g] = pending_q[qaddr_i[g*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardware zero-initialisation and a
// per-register pending scoreboard.
//  - After reset a CLEAR sequence writes zero to registers 1..NREG-1, one per
//    cycle; ready rises once the last register is written. While clearing,
//    writes and scoreboard sets are dropped and all read ports return zero.
//  - Register 0 is hard-wired to zero; a write to it is discarded and flagged
//    by a one-cycle wr_x0_err pulse.
//  - Optional macro RF_BYPASS_EN forwards same-cycle write data to matching
//    read ports (unless a scoreboard set targets that register in the same
//    cycle, in which case the port sees the stored value and pending bit).
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRP  = NRP_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  output logic [NRP-1:0]      rbusy,
  output logic                ready,
  output logic                wr_x0_err
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  rf_state_e         state_q;
  logic [AW-1:0]     cnt_q;
  logic              ready_q;
  logic              wr_x0_err_q;
  logic [XLEN-1:0]   mem_q [NREG];

  logic              wr_commit;
  logic              wr_x0;
  logic              sb_set_eff;
  logic [NRP-1:0]    sb_busy;

  // Requests only take effect once the clear sequence has finished.
  assign wr_commit  = ready_q && we && (waddr != '0);
  assign wr_x0      = ready_q && we && (waddr == '0);
  assign sb_set_eff = ready_q && sb_set;

  // Clear/ready controller with registered ready and x0-write error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= AW'(1);
      ready_q     <= 1'b0;
      wr_x0_err_q <= 1'b0;
    end else begin
      wr_x0_err_q <= wr_x0;
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= CLEAR;
          cnt_q   <= AW'(1);
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Register storage: zero-fill during CLEAR, committed writes in READY.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_commit) begin
        mem_q[waddr] <= wdata;
      end
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .NRP  (NRP)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_i      (sb_set_eff),
    .set_addr_i (sb_addr),
    .clr_i      (wr_commit),
    .clr_addr_i (waddr),
    .qaddr_i    (raddr),
    .busy_o     (sb_busy)
  );

  for (genvar g = 0; g < NRP; g++) begin : g_rport
    logic [AW-1:0]   ra;
    logic            byp;
    logic [XLEN-1:0] rd;
    logic            bz;

    assign ra = raddr[g*AW +: AW];

`ifdef RF_BYPASS_EN
    assign byp = wr_commit && (waddr == ra) && !(sb_set && (sb_addr == waddr));
`else
    assign byp = 1'b0;
`endif

    // Combinational read: zero while clearing or for x0, forwarded data on bypass.
    always_comb begin
      rd = '0;
      bz = 1'b0;
      if (byp) begin
        rd = wdata;
        bz = 1'b0;
      end else if (ready_q && (ra != '0)) begin
        rd = mem_q[ra];
        bz = sb_busy[g];
      end
    end

    assign rdata[g*XLEN +: XLEN] = rd;
    assign rbusy[g]              = bz;
  end

  assign ready     = ready_q;
  assign wr_x0_err = wr_x0_err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp (default geometry: 32 x 32-bit, 2 read ports).
// Expected values that depend on same-cycle forwarding follow RF_BYPASS_EN.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic [NRP-1:0]      rbusy;
  logic                ready;
  logic                wr_x0_err;

  int checks = 0;
  int errors = 0;

  regfile_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRP  (NRP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .sb_set    (sb_set),
    .sb_addr   (sb_addr),
    .rbusy     (rbusy),
    .ready     (ready),
    .wr_x0_err (wr_x0_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        sbs;
    logic [4:0]  sba;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic        ex0;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic s, input logic [4:0] sa,
                       input logic [4:0] r0, input logic [4:0] r1);
    we      = w;
    waddr   = wa;
    wdata   = wd;
    sb_set  = s;
    sb_addr = sa;
    raddr   = {r1, r0};
  endtask

  // Runs a clear sequence after rst has just been released. Edges are counted
  // from the release. If rst_at > 0, rst is pulsed after that many edges and
  // counting restarts. At inj_at a write to reg 2 and a set of reg 4 are
  // issued for one cycle. When chk_first is set, reads are checked after edge 1.
  task automatic clear_run(input int rst_at, input int inj_at, input bit chk_first,
                           input string tag, output int n);
    int  ra_n;
    bit  done;
    ra_n = rst_at;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) begin
        done = 1'b1;
      end else if (n >= 100) begin
        done = 1'b1;
      end else begin
        if (chk_first && n == 1) begin
          #1;
          chk({tag, ".clear_rdata0"}, rdata[31:0], 32'h0);
          chk({tag, ".clear_rbusy"}, {30'b0, rbusy}, 32'h0);
          chk({tag, ".clear_ready"}, {31'b0, ready}, 32'h0);
        end
        if (ra_n > 0 && n == ra_n) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          rst  = 1'b0;
          n    = 0;
          ra_n = 0;
        end
        if (inj_at > 0 && n == inj_at) begin
          drive(1'b1, 5'd2, 32'h00000BAD, 1'b1, 5'd4, 5'd2, 5'd4);
        end
        if (inj_at > 0 && n == inj_at + 1) begin
          drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd4);
        end
      end
    end
  endtask

  initial begin : main
    int n;

    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0,
                 BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5,
                 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0};
    vecs[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 2'b00, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5,
                 32'h0, 32'hDEADBEEF, 2'b00, 1'b1};
    vecs[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0,
                 32'h0, 32'h0, 2'b00, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                 32'h0, 32'h0, 2'b11, 1'b0};
    vecs[7]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd5,
                 BYP ? 32'hA5A5A5A5 : 32'h0, 32'hDEADBEEF, BYP ? 2'b00 : 2'b01, 1'b0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                 32'hA5A5A5A5, 32'h0, 2'b00, 1'b0};
    vecs[9]  = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 5'd3, 5'd3,
                 32'h0, 32'h0, 2'b00, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9,
                 32'h11, 32'h0, 2'b01, 1'b0};
    vecs[11] = '{1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 5'd3, 5'd9,
                 32'h11, BYP ? 32'hCAFEF00D : 32'h0, 2'b01, 1'b0};
    vecs[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3,
                 32'hCAFEF00D, 32'h11, 2'b10, 1'b0};
    vecs[13] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 2'b00, 1'b0};
    vecs[14] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3,
                 32'h0, 32'h11, 2'b10, 1'b0};
    vecs[15] = '{1'b1, 5'd3, 32'h22, 1'b1, 5'd6, 5'd6, 5'd3,
                 32'h0, BYP ? 32'h22 : 32'h11, BYP ? 2'b00 : 2'b10, 1'b0};
    vecs[16] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd3,
                 32'h0, 32'h22, 2'b01, 1'b0};

    // Initial reset and power-up clear.
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst.ready", {31'b0, ready}, 32'h0);
    chk("rst.wr_x0_err", {31'b0, wr_x0_err}, 32'h0);
    chk("rst.rbusy", {30'b0, rbusy}, 32'h0);
    chk("rst.rdata0", rdata[31:0], 32'h0);
    rst = 1'b0;
    clear_run(0, 0, 1'b0, "init", n);
    chk("init.edges_to_ready", n, 31);

    // Table-driven traffic in READY.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].sbs, vecs[i].sba,
            vecs[i].ra0, vecs[i].ra1);
      #1;
      chk($sformatf("v%0d.rdata0", i), rdata[31:0], vecs[i].e0);
      chk($sformatf("v%0d.rdata1", i), rdata[63:32], vecs[i].e1);
      chk($sformatf("v%0d.rbusy", i), {30'b0, rbusy}, {30'b0, vecs[i].eb});
      chk($sformatf("v%0d.wr_x0_err", i), {31'b0, wr_x0_err}, {31'b0, vecs[i].ex0});
      chk($sformatf("v%0d.ready", i), {31'b0, ready}, 32'h1);
      @(posedge clk);
      #1;
    end

    // Reset pulse in READY: reg 5 (0xDEADBEEF) and pending reg 6 must be wiped.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst2.ready", {31'b0, ready}, 32'h0);
    chk("rst2.wr_x0_err", {31'b0, wr_x0_err}, 32'h0);
    clear_run(0, 0, 1'b1, "rst2", n);
    chk("rst2.edges_to_ready", n, 31);
    #1;
    chk("rst2.reg5", rdata[31:0], 32'h0);
    chk("rst2.rbusy6", {30'b0, rbusy}, 32'h0);

    // Write reg 2 in READY so a leaked write during the next clear is visible.
    drive(1'b1, 5'd2, 32'h0000F00D, 1'b0, 5'd0, 5'd2, 5'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd4);
    #1;
    chk("pre3.reg2", rdata[31:0], 32'h0000F00D);

    // Mid-clear reset at clear cycle 10, then dropped write/set at cycle 19.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_run(10, 19, 1'b0, "rst3", n);
    chk("rst3.edges_to_ready", n, 31);
    #1;
    chk("rst3.reg2", rdata[31:0], 32'h0);
    chk("rst3.rbusy4", {30'b0, rbusy}, 32'h0);

    // Normal write/read after re-clear.
    drive(1'b1, 5'd31, 32'h5A5A0001, 1'b0, 5'd0, 5'd31, 5'd31);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd31);
    #1;
    chk("post.rdata0", rdata[31:0], 32'h5A5A0001);
    chk("post.rdata1", rdata[63:32], 32'h5A5A0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
